// File: rtl/if_stage_pkg.sv
// Shared datapath definitions for the fetch stage: next-PC select codes,
// reset constants and the IF/ID payload.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    // Targets are word addresses; the byte-offset bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] adr);
        return {adr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: async reset to RESET_PC, loads only when enabled.
module pc_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC and fills the
// IF/ID register with the fetched word or a bubble on redirect/flush.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_adr,
    input  logic [31:0] inst_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] br_adr,
    input  logic [31:0] jr_adr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_cnt
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] jump_tgt;
    if_id_t          if_id_q;
    if_id_t          if_id_d;
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] fetch_cnt_d;

    pc_reg u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (~stall),
        .pc_d (pc_d),
        .pc_q (pc_q)
    );

    assign pc4      = pc_q + XLEN'(4);
    assign jump_tgt = {if_id_q.pc4[31:28], if_id_q.inst[25:0], 2'b00};

    // Next-PC select; stall is handled by the PC load enable.
    always_comb begin
        pc_d = pc4;
        unique case (pc_src_e'(pc_src))
            PC_SEQ: pc_d = pc4;
            PC_BR:  pc_d = word_align(br_adr);
            PC_J:   pc_d = word_align(jump_tgt);
            PC_JR:  pc_d = word_align(jr_adr);
            default: pc_d = pc4;
        endcase
    end

    // IF/ID next state: hold on stall, bubble on redirect or flush.
    always_comb begin
        if_id_d     = if_id_q;
        fetch_cnt_d = fetch_cnt_q;
        if (!stall) begin
            if ((pc_src != 2'b00) || flush) begin
                if_id_d.valid = 1'b0;
                if_id_d.inst  = NOP_INST;
                if_id_d.pc4   = '0;
            end else begin
                if_id_d.valid = 1'b1;
                if_id_d.inst  = inst_in;
                if_id_d.pc4   = pc4;
                fetch_cnt_d   = fetch_cnt_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q.valid <= 1'b0;
            if_id_q.inst  <= NOP_INST;
            if_id_q.pc4   <= '0;
            fetch_cnt_q   <= '0;
        end else begin
            if_id_q     <= if_id_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign inst_adr    = pc_q;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, jump, branch, jr, stall,
// wrap, flush and asynchronous reset against hand-computed values.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] inst_adr;
    logic [31:0] inst_in;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] br_adr;
    logic [31:0] jr_adr;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .inst_adr    (inst_adr),
        .inst_in     (inst_in),
        .stall       (stall),
        .flush       (flush),
        .pc_src      (pc_src),
        .br_adr      (br_adr),
        .jr_adr      (jr_adr),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word 12 is j 6, every other word is an addi tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] adr);
        if (adr == 32'd12) return {6'b000010, 26'd6};
        return 32'h2000_0000 | {16'h0, adr[15:0]};
    endfunction

    always_comb inst_in = mem_word(inst_adr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] adr, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
        check({tag, ".adr"},   inst_adr, adr);
        check({tag, ".inst"},  if_id_inst, inst);
        check({tag, ".pc4"},   if_id_pc4, pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".cnt"},   fetch_cnt, cnt);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
        br_adr = '0; jr_adr = '0;
        step; step;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0;

        step; check_all("seq1", 32'd4,  32'h2000_0000, 32'd4,  1'b1, 32'd1);
        step; check_all("seq2", 32'd8,  32'h2000_0004, 32'd8,  1'b1, 32'd2);
        step; check_all("seq3", 32'd12, 32'h2000_0008, 32'd12, 1'b1, 32'd3);
        step; check_all("jword", 32'd16, 32'h0800_0006, 32'd16, 1'b1, 32'd4);

        pc_src = 2'b10;
        step; check_all("jump", 32'd24, 32'h0, 32'h0, 1'b0, 32'd4);
        pc_src = 2'b00;
        step; check_all("jtgt", 32'd28, 32'h2000_0018, 32'd28, 1'b1, 32'd5);

        pc_src = 2'b01; br_adr = 32'h40;
        step; check_all("br", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
        pc_src = 2'b00;
        step; check_all("brtgt", 32'h44, 32'h2000_0040, 32'h44, 1'b1, 32'd6);

        pc_src = 2'b11; jr_adr = 32'h103;
        step; check_all("jr", 32'h100, 32'h0, 32'h0, 1'b0, 32'd6);
        pc_src = 2'b00;
        step; check_all("jrtgt", 32'h104, 32'h2000_0100, 32'h104, 1'b1, 32'd7);

        pc_src = 2'b11; jr_adr = 32'h8;
        step; check_all("jr8", 32'h8, 32'h0, 32'h0, 1'b0, 32'd7);

        stall = 1'b1; pc_src = 2'b01; br_adr = 32'h40;
        step; check_all("stall1", 32'h8, 32'h0, 32'h0, 1'b0, 32'd7);
        step; check_all("stall2", 32'h8, 32'h0, 32'h0, 1'b0, 32'd7);
        stall = 1'b0; pc_src = 2'b00;
        step; check_all("unstall", 32'hC, 32'h2000_0008, 32'hC, 1'b1, 32'd8);

        pc_src = 2'b11; jr_adr = 32'hFFFF_FFFC;
        step; check_all("jrtop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd8);
        pc_src = 2'b00;
        step; check_all("wrap", 32'h0, 32'h2000_FFFC, 32'h0, 1'b1, 32'd9);

        flush = 1'b1;
        step; check_all("flush", 32'h4, 32'h0, 32'h0, 1'b0, 32'd9);
        flush = 1'b0;
        step; check_all("postflush", 32'h8, 32'h2000_0004, 32'h8, 1'b1, 32'd10);

        #2 rst = 1'b1;
        #1 check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step; check_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0;
        step; check_all("refetch", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the MIPS datapath. It owns the program counter, drives the word address into the instruction memory, and registers the returned instruction with PC+4 into the IF/ID pipeline register for the decode stage. Redirects come from decode: branch and jr targets arrive as inputs, and the jump target is formed internally from the instruction held in IF/ID. Stall and flush controls come from the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inst_adr  output  32  fetch address to instruction memory; always equals the PC register.
- inst_in  input  32  instruction word returned combinationally by instruction memory for inst_adr.
- stall  input  1  hold the PC and IF/ID (load-use hazard).
- flush  input  1  write a bubble into IF/ID on the next edge.
- pc_src  input  2  next-PC select: 00 = PC+4, 01 = br_adr, 10 = jump, 11 = jr_adr.
- br_adr  input  32  branch target computed in decode.
- jr_adr  input  32  register target for jr.
- if_id_inst  output  32  registered instruction.
- if_id_pc4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- fetch_cnt  output  32  count of instructions accepted into IF/ID since reset.

## Operation
- pc4 = pc + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- Jump target = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00}.
- The low two bits of every selected target are forced to 00.
- Priority at each rising edge:
  - rst: highest priority.
  - stall: PC, IF/ID, and fetch_cnt all hold. pc_src and flush are ignored; decode re-asserts them after the stall.
  - Redirect (pc_src != 00): PC loads the selected target. IF/ID takes the bubble: if_id_inst = NOP_INST, if_id_pc4 = 0, if_id_valid = 0. This squashes the wrong-path instruction fetched this cycle.
  - flush with pc_src = 00: PC = pc4, and IF/ID takes the bubble.
  - Otherwise: PC = pc4, if_id_inst = inst_in, if_id_pc4 = pc4, if_id_valid = 1, and fetch_cnt increments.
- fetch_cnt increments only when a valid instruction is written into IF/ID. It wraps at 2^32.
- No internal FSM beyond the PC and IF/ID registers. Program state is fully defined by pc and if_id_valid.

## Timing
- Reset values (asynchronous, effective while rst = 1):
  - pc = RESET_PC, so inst_adr = RESET_PC.
  - if_id_inst = NOP_INST, if_id_pc4 = 0, if_id_valid = 0, fetch_cnt = 0.
- inst_adr is a direct register output with zero combinational logic.
- Instruction memory is combinational. The word at address A appears in IF/ID one edge after inst_adr = A.
- Redirect penalty is one bubble. A redirect decided in ID at edge N puts the target address on inst_adr after N. The target instruction reaches IF/ID at N+1.
- rst asserted mid-stream takes effect immediately and without waiting for clk. The first fetch from RESET_PC is latched on the first edge after rst deasserts.
- Stall and redirect in the same cycle: stall wins and nothing changes.

## Structure
- Put the pc_src encodings (PC_SEQ, PC_BR, PC_J, PC_JR) in the shared datapath defines header, where the controller also uses them.
- Sub-module pc_reg: a 32-bit register with async reset to RESET_PC and a load enable. if_stage instantiates it with load = ~stall.
- The IF/ID register, next-PC mux, jump-target concatenation, and fetch counter stay inline.

## Test plan
- **Reset and sequential fetch.**
  - Stimulus: rst pulse, then memory holds addi words at 0, 4, 8.
  - Required: inst_adr steps 0, 4, 8, 12 on successive edges. if_id_pc4 steps 4, 8, 12. if_id_valid rises on the first edge. fetch_cnt = 3 after three edges.
- **Jump.**
  - Stimulus: word at 12 = {6'b000010, 26'd6}. While it sits in IF/ID, drive pc_src = 10.
  - Required: next inst_adr = 24. IF/ID holds a bubble (valid 0, inst 0), so the word at 16 is squashed. The next edge latches the word at 24 with if_id_pc4 = 28.
- **Branch and jr.**
  - Stimulus: pc_src = 01 with br_adr = 0x40, then pc_src = 11 with jr_adr = 0x103.
  - Required: inst_adr = 0x40, then 0x100 (low bits forced to 00). Each redirect produces exactly one bubble.
- **Stall.**
  - Stimulus: hold stall for 2 cycles at PC = 8, with pc_src = 01 during the stall.
  - Required: inst_adr, IF/ID, and fetch_cnt unchanged for both cycles. The redirect is ignored. PC = 12 on the first edge after stall drops.
- **Wrap, flush, and async reset.**
  - Stimulus: jr to 0xFFFF_FFFC. Then assert flush alone. Then assert rst between clock edges.
  - Required: wrap gives inst_adr = 0, with if_id_pc4 = 0 for the instruction fetched at 0xFFFF_FFFC. flush gives a bubble while PC still advances by 4. rst forces all outputs to their reset values immediately, without waiting for an edge.
